// File: rtl/return_address_stack_ckpt_if.sv
// Decode, checkpoint and prediction signals between the fetch/branch pipeline and the RAS.
// Width parameters must match those of the attached return_address_stack_ckpt instance.
interface return_address_stack_ckpt_if #(
  parameter int DEPTH_IDX = 3,
  parameter int XLEN      = 32
);
  localparam int CKPT_W = 2*DEPTH_IDX + 1 + XLEN;

  logic              stall;
  logic              inst_valid;
  logic [XLEN-1:0]   pc;
  logic [6:0]        opcode;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic              recover;
  logic [CKPT_W-1:0] ckpt_in;
  logic [XLEN-1:0]   ras_out;
  logic              ras_valid;
  logic              is_call;
  logic              is_return;
  logic [CKPT_W-1:0] ckpt_out;

  modport master (
    output stall, inst_valid, pc, opcode, rd, rs1, recover, ckpt_in,
    input  ras_out, ras_valid, is_call, is_return, ckpt_out
  );

  modport slave (
    input  stall, inst_valid, pc, opcode, rd, rs1, recover, ckpt_in,
    output ras_out, ras_valid, is_call, is_return, ckpt_out
  );
endinterface

// File: rtl/return_address_stack_ckpt.sv
// Circular return-address stack with per-instruction checkpoint export and mispredict restore.
// Calls/returns are decoded from JAL/JALR link-register hints; updates land one cycle after decode.
module return_address_stack_ckpt #(
  parameter int DEPTH_IDX = 3,
  parameter int XLEN      = 32,
  parameter int ALT_LINK  = 1
) (
  input logic clk,
  input logic rst,
  return_address_stack_ckpt_if.slave bus
);
  localparam int unsigned D      = 1 << DEPTH_IDX;
  localparam int          CKPT_W = 2*DEPTH_IDX + 1 + XLEN;
  localparam logic [6:0]  OP_JAL  = 7'b1101111;
  localparam logic [6:0]  OP_JALR = 7'b1100111;
  localparam logic [DEPTH_IDX:0] CNT_FULL = (DEPTH_IDX+1)'(D);

  logic [XLEN-1:0]      stack [D];
  logic [DEPTH_IDX-1:0] ptr;
  logic [DEPTH_IDX-1:0] ptr_m1;
  logic [DEPTH_IDX:0]   count;
  logic [XLEN-1:0]      ret_addr;

  logic                 jal_dec;
  logic                 jalr_dec;
  logic                 rd_link;
  logic                 rs1_link;
  logic                 do_push;
  logic                 do_pop;
  logic                 do_corout;

  logic [DEPTH_IDX:0]   ck_count;
  logic [DEPTH_IDX-1:0] ck_ptr;
  logic [DEPTH_IDX-1:0] ck_ptr_m1;
  logic [XLEN-1:0]      ck_top;

  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || ((ALT_LINK != 0) && (r == 5'd5));
  endfunction

  always_comb begin
    jal_dec   = bus.inst_valid && (bus.opcode == OP_JAL);
    jalr_dec  = bus.inst_valid && (bus.opcode == OP_JALR);
    rd_link   = is_link(bus.rd);
    rs1_link  = is_link(bus.rs1);
    // Coroutine (both links, distinct regs) is a pop-then-push; same-reg JALR is a plain push.
    do_corout = jalr_dec && rd_link && rs1_link && (bus.rd != bus.rs1);
    do_push   = (jal_dec && rd_link) || (jalr_dec && rd_link && !do_corout);
    do_pop    = jalr_dec && !rd_link && rs1_link;
  end

  always_comb begin
    ptr_m1    = ptr - 1'b1;
    ret_addr  = bus.pc + XLEN'(4);
    ck_count  = bus.ckpt_in[CKPT_W-1 -: DEPTH_IDX+1];
    ck_ptr    = bus.ckpt_in[XLEN +: DEPTH_IDX];
    ck_top    = bus.ckpt_in[XLEN-1:0];
    ck_ptr_m1 = ck_ptr - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
      stack <= '{default: '0};
    end else if (bus.recover) begin
      ptr   <= ck_ptr;
      count <= ck_count;
      if (ck_count != '0) stack[ck_ptr_m1] <= ck_top;
    end else if (!bus.stall) begin
      if (do_corout && count != '0) begin
        stack[ptr_m1] <= ret_addr;
      end else if (do_push || do_corout) begin
        // Full stack: the write at ptr silently replaces the oldest entry.
        stack[ptr] <= ret_addr;
        ptr        <= ptr + 1'b1;
        if (count != CNT_FULL) count <= count + 1'b1;
      end else if (do_pop && count != '0) begin
        ptr   <= ptr_m1;
        count <= count - 1'b1;
      end
    end
  end

  always_comb begin
    bus.ras_out   = stack[ptr_m1];
    bus.ras_valid = (count != '0);
    bus.is_call   = do_push || do_corout;
    bus.is_return = do_pop || do_corout;
    bus.ckpt_out  = {count, ptr, stack[ptr_m1]};
  end
endmodule

// File: tb/tb_return_address_stack_ckpt.sv
// Scoreboard bench for return_address_stack_ckpt (4-entry stack): directed decode/recover vectors
// push expected responses; a negedge monitor pops and compares them in cycle order.
module tb_return_address_stack_ckpt;
  localparam int DI     = 2;
  localparam int XL     = 32;
  localparam int CKPT_W = 2*DI + 1 + XL;
  localparam logic [6:0] JAL  = 7'h6F;
  localparam logic [6:0] JALR = 7'h67;
  localparam logic [6:0] ADDI = 7'h13;
  localparam int K_ST = 0, K_DEC = 1, K_CK = 2;

  typedef struct {
    int              cyc;
    string           name;
    int              kind;
    logic [XL-1:0]   ras;
    logic            vld;
    logic [DI:0]     cnt;
    logic            call;
    logic            ret;
    logic [CKPT_W-1:0] ck;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t sb[$];

  return_address_stack_ckpt_if #(.DEPTH_IDX(DI), .XLEN(XL)) bus ();

  return_address_stack_ckpt #(.DEPTH_IDX(DI), .XLEN(XL), .ALT_LINK(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every expectation stamped for this cycle is checked at the falling edge.
  exp_t e;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_cmp++;
      case (e.kind)
        K_ST: if (bus.ras_out !== e.ras || bus.ras_valid !== e.vld ||
                  bus.ckpt_out[CKPT_W-1 -: DI+1] !== e.cnt) begin
          n_fail++;
          $display("FAIL %s: got ras_out=%h ras_valid=%b count=%0d, expected ras_out=%h ras_valid=%b count=%0d",
                   e.name, bus.ras_out, bus.ras_valid, bus.ckpt_out[CKPT_W-1 -: DI+1], e.ras, e.vld, e.cnt);
        end
        K_DEC: if (bus.is_call !== e.call || bus.is_return !== e.ret) begin
          n_fail++;
          $display("FAIL %s: got is_call=%b is_return=%b, expected is_call=%b is_return=%b",
                   e.name, bus.is_call, bus.is_return, e.call, e.ret);
        end
        default: if (bus.ckpt_out !== e.ck) begin
          n_fail++;
          $display("FAIL %s: got ckpt_out=%h, expected ckpt_out=%h", e.name, bus.ckpt_out, e.ck);
        end
      endcase
    end
  end

  task automatic go(input logic [6:0] o, input logic [4:0] d, input logic [4:0] s,
                    input logic [XL-1:0] p, input bit v = 1'b1, input bit st = 1'b0,
                    input bit rc = 1'b0, input logic [CKPT_W-1:0] ck = '0, input bit r = 1'b0);
    @(posedge clk); #1;
    rst            = r;
    bus.inst_valid = v;
    bus.opcode     = o;
    bus.rd         = d;
    bus.rs1        = s;
    bus.pc         = p;
    bus.stall      = st;
    bus.recover    = rc;
    bus.ckpt_in    = ck;
  endtask

  task automatic exp_st(input string nm, input logic [XL-1:0] ras, input logic vld, input logic [DI:0] cnt);
    exp_t x;
    x.cyc = cyc + 1; x.name = nm; x.kind = K_ST;
    x.ras = ras; x.vld = vld; x.cnt = cnt; x.call = 1'b0; x.ret = 1'b0; x.ck = '0;
    sb.push_back(x);
  endtask

  task automatic exp_dec(input string nm, input logic call, input logic ret);
    exp_t x;
    x.cyc = cyc; x.name = nm; x.kind = K_DEC;
    x.ras = '0; x.vld = 1'b0; x.cnt = '0; x.call = call; x.ret = ret; x.ck = '0;
    sb.push_back(x);
  endtask

  // Checkpoint of the state present during the current cycle (before this edge's update).
  task automatic exp_ck(input string nm, input logic [CKPT_W-1:0] ck);
    exp_t x;
    x.cyc = cyc; x.name = nm; x.kind = K_CK;
    x.ras = '0; x.vld = 1'b0; x.cnt = '0; x.call = 1'b0; x.ret = 1'b0; x.ck = ck;
    sb.push_back(x);
  endtask

  initial begin
    bus.inst_valid = 1'b0; bus.opcode = '0; bus.rd = '0; bus.rs1 = '0; bus.pc = '0;
    bus.stall = 1'b0; bus.recover = 1'b0; bus.ckpt_in = '0;

    // Reset and first call
    go(ADDI, 0, 0, 0, 0, 0, 0, '0, 1);   exp_st("reset_state", 0, 0, 0);
    go(JAL, 1, 0, 32'h100);              exp_ck("reset_ckpt", '0); exp_dec("jal_x1_dec", 1, 0);
                                         exp_st("jal_x1_push", 32'h104, 1, 1);
    go(JAL, 1, 0, 32'h900, 0);           exp_dec("jal_invalid_dec", 0, 0);
                                         exp_st("jal_invalid_nochg", 32'h104, 1, 1);
    go(JAL, 0, 0, 32'h900);              exp_dec("jal_x0_dec", 0, 0);
                                         exp_st("jal_x0_nochg", 32'h104, 1, 1);

    // Fill past depth 4, then drain
    go(ADDI, 0, 0, 0, 0, 0, 0, '0, 1);   exp_st("reset2", 0, 0, 0);
    go(JAL, 1, 0, 32'h10);               exp_st("fill_1", 32'h14, 1, 1);
    go(JAL, 1, 0, 32'h20);               exp_st("fill_2", 32'h24, 1, 2);
    go(JAL, 5, 0, 32'h30);               exp_dec("jal_x5_dec", 1, 0); exp_st("fill_3", 32'h34, 1, 3);
    go(JAL, 1, 0, 32'h40);               exp_st("fill_4", 32'h44, 1, 4);
    go(JAL, 1, 0, 32'h50);               exp_st("fill_5_overwrite", 32'h54, 1, 4);
    go(JALR, 2, 3, 32'h60);              exp_dec("jalr_nonlink_dec", 0, 0);
                                         exp_st("jalr_nonlink_nochg", 32'h54, 1, 4);
    go(JALR, 0, 1, 32'h60);              exp_dec("pop_dec", 0, 1); exp_st("pop_1", 32'h44, 1, 3);
    go(JALR, 0, 5, 32'h60);              exp_st("pop_2_x5", 32'h34, 1, 2);
    go(JALR, 0, 1, 32'h60);              exp_st("pop_3", 32'h24, 1, 1);
    go(JALR, 0, 1, 32'h60);              exp_st("pop_4_empty", 32'h54, 0, 0);

    // Pop on empty, same-reg JALR push
    go(JALR, 0, 1, 32'h60);              exp_dec("pop_empty_dec", 0, 1);
                                         exp_st("pop_empty_nochg", 32'h54, 0, 0);
    go(JALR, 1, 1, 32'h200);             exp_dec("jalr_same_dec", 1, 0);
                                         exp_st("jalr_same_push", 32'h204, 1, 1);

    // Coroutine swaps the top in place
    go(JAL, 1, 0, 32'h100);              exp_st("corout_setup", 32'h104, 1, 2);
    go(JALR, 5, 1, 32'h300);             exp_dec("corout_dec", 1, 1);
                                         exp_st("corout_swap", 32'h304, 1, 2);

    // Checkpoint, wrong-path pop/push, recover
    go(ADDI, 0, 0, 0, 0, 0, 0, '0, 1);   exp_st("reset3", 0, 0, 0);
    go(JAL, 1, 0, 32'h100);              exp_st("ckpt_setup", 32'h104, 1, 1);
    go(JALR, 0, 1, 32'h180);             exp_ck("ckpt_capture", {3'd1, 2'd1, 32'h104});
                                         exp_st("wrong_pop", 32'h0, 0, 0);
    go(JAL, 1, 0, 32'h400);              exp_st("wrong_push", 32'h404, 1, 1);
    go(JAL, 1, 0, 32'h500, 1, 0, 1, {3'd1, 2'd1, 32'h104});
                                         exp_dec("recover_dec_comb", 1, 0);
                                         exp_st("recover_restore", 32'h104, 1, 1);
    go(ADDI, 0, 0, 0, 0);                exp_ck("recover_ckpt", {3'd1, 2'd1, 32'h104});

    // Stall, recover under stall with wrapped pointer, reset beats recover
    go(JAL, 1, 0, 32'h600, 1, 1);        exp_dec("stall_dec", 1, 0);
                                         exp_st("stall_nochg", 32'h104, 1, 1);
    go(JAL, 1, 0, 32'h650, 1, 1, 1, {3'd2, 2'd0, 32'hABC});
                                         exp_st("recover_stall_wrap", 32'hABC, 1, 2);
    go(JAL, 1, 0, 32'h680, 1, 0, 1, {3'd1, 2'd1, 32'h777}, 1);
                                         exp_ck("pre_reset_ckpt", {3'd2, 2'd0, 32'hABC});
                                         exp_st("rst_beats_recover", 0, 0, 0);

    // Coroutine on empty stack acts as a push; pc+4 wraps
    go(JALR, 1, 5, 32'h700);             exp_ck("post_reset_ckpt", '0);
                                         exp_st("corout_empty_push", 32'h704, 1, 1);
    go(JAL, 1, 0, 32'hFFFF_FFFC);        exp_st("pc_wrap_push", 32'h0, 1, 2);
    go(ADDI, 0, 0, 0, 0);                exp_ck("final_ckpt", {3'd2, 2'd2, 32'h0});

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
